// File: rtl/sys_defs.sv
// Shared fetch/dispatch definitions: the IF_IB_PACKET record, the `NOP encoding and IB_DEPTH.
// The `NOP macro is defined here and mirrored by the NOP_INST package constant.
`ifndef SYS_DEFS_NOP_DEFINED
`define SYS_DEFS_NOP_DEFINED
`define NOP 32'h0000_0013
`endif

package sys_defs;

    localparam int XLEN     = 32;
    localparam int IB_DEPTH = 8;

    localparam logic [XLEN-1:0] NOP_INST = `NOP;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] NPC;
        logic [XLEN-1:0] PC;
        logic            pred_bp_taken;
    } IF_IB_PACKET;

    // The idle packet presented when nothing is buffered: all zero except a NOP instruction.
    function automatic IF_IB_PACKET idle_packet();
        IF_IB_PACKET p;
        p      = '0;
        p.inst = NOP_INST;
        return p;
    endfunction

endpackage

// File: rtl/ib_ptr_ctrl.sv
// Circular-queue pointer/occupancy controller: head, tail and count with full/empty decode.
// Usable by any power-of-two ring buffer (instruction buffer, ROB, free lists).
module ib_ptr_ctrl #(
    parameter  int DEPTH = 8,
    parameter  int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    output logic [PTR_W-1:0] head,
    output logic [PTR_W-1:0] tail,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [PTR_W-1:0] head_nxt;
    logic [PTR_W-1:0] tail_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Guard against callers that push into a full queue or pop an empty one.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path can infer a latch.
        head_nxt  = head;
        tail_nxt  = tail;
        count_nxt = count;
        if (flush) begin
            head_nxt  = '0;
            tail_nxt  = '0;
            count_nxt = '0;
        end else begin
            if (do_push) tail_nxt = tail + PTR_W'(1);
            if (do_pop)  head_nxt = head + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_nxt = count + CNT_W'(1);
                2'b01:   count_nxt = count - CNT_W'(1);
                default: count_nxt = count;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head_nxt;
            tail  <= tail_nxt;
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and dispatch: FWFT circular FIFO with flush and sticky overflow.
// Optional IB_BYPASS_EN macro: an empty buffer forwards the incoming packet in the same cycle.
module inst_buffer
    import sys_defs::*;
#(
    parameter int DEPTH = IB_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  IF_IB_PACKET      if_ib_packet,
    input  logic             flush,
    input  logic             dp_ready,
    output IF_IB_PACKET      ib_dp_packet,
    output logic             ib_full,
    output logic             ib_empty,
    output logic [CNT_W-1:0] ib_count,
    output logic             ib_overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);

    IF_IB_PACKET      mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             push_req;
    logic             bypass_take;
    logic             do_push;
    logic             do_pop;

    // A wrong-path packet arriving with a flush is never a candidate for storage or bypass.
    assign push_req = if_ib_packet.valid & ~flush;

`ifdef IB_BYPASS_EN
    // Empty buffer, dispatch ready: the packet goes straight through and is never stored.
    assign bypass_take = push_req & ib_empty & dp_ready;
`else
    assign bypass_take = 1'b0;
`endif

    assign do_push = push_req & ~ib_full & ~bypass_take;
    assign do_pop  = ~ib_empty & dp_ready & ~flush;

    ib_ptr_ctrl #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_ptr_ctrl (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (do_push),
        .pop     (do_pop),
        .flush   (flush),
        .head    (head),
        .tail    (tail),
        .count   (ib_count),
        .full    (ib_full),
        .empty   (ib_empty)
    );

    // NOTE: the data array has no reset; validity comes only from the reset count.
    always_ff @(posedge clock) begin
        if (do_push) mem[tail] <= if_ib_packet;
    end

    always_comb begin
        ib_dp_packet = idle_packet();
        if (!ib_empty) begin
            ib_dp_packet       = mem[head];
            ib_dp_packet.valid = 1'b1;
        end
`ifdef IB_BYPASS_EN
        else if (push_req) begin
            ib_dp_packet = if_ib_packet;
        end
`endif
    end

    // Sticky: a push offered while full is dropped and only reset clears the flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ib_overflow_err <= 1'b0;
        end else if (if_ib_packet.valid & ib_full & ~flush) begin
            ib_overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: vector table, scoreboard queue and multi-cycle corner sequences.
module tb_inst_buffer;
    import sys_defs::*;

    localparam int DEPTH = IB_DEPTH;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clock = 1'b0;
    logic             reset_n;
    IF_IB_PACKET      if_ib_packet;
    logic             flush;
    logic             dp_ready;
    IF_IB_PACKET      ib_dp_packet;
    logic             ib_full;
    logic             ib_empty;
    logic [CNT_W-1:0] ib_count;
    logic             ib_overflow_err;

    always #5 clock = ~clock;

    inst_buffer #(.DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .if_ib_packet    (if_ib_packet),
        .flush           (flush),
        .dp_ready        (dp_ready),
        .ib_dp_packet    (ib_dp_packet),
        .ib_full         (ib_full),
        .ib_empty        (ib_empty),
        .ib_count        (ib_count),
        .ib_overflow_err (ib_overflow_err)
    );

    int          checks   = 0;
    int          failures = 0;
    IF_IB_PACKET sb_q[$];
    logic        m_ovf;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        rdy;
        logic        fl;
        int          e_cnt;
        logic        e_full;
        logic        e_ovf;
        logic [31:0] e_head;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic IF_IB_PACKET make_pkt(input logic [31:0] pc, input logic v);
        IF_IB_PACKET p;
        p.valid         = v;
        p.PC            = pc;
        p.NPC           = pc + 32'd4;
        p.inst          = 32'h00A0_0093 + pc;
        p.pred_bp_taken = pc[2];
        return p;
    endfunction

    task automatic set_in(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        if_ib_packet = make_pkt(pc, v);
        dp_ready     = rdy;
        flush        = fl;
        #1;
    endtask

    // Scoreboard update for the cycle whose inputs are currently driven, then clock it.
    task automatic commit();
        int          sz;
        bit          bypassed;
        IF_IB_PACKET exp;
        sz       = sb_q.size();
        bypassed = 1'b0;
        if (flush) begin
            sb_q.delete();
        end else begin
`ifdef IB_BYPASS_EN
            if (sz == 0 && if_ib_packet.valid) begin
                check("bypass_valid", 32'(ib_dp_packet.valid), 32'd1);
                check("bypass_pc", ib_dp_packet.PC, if_ib_packet.PC);
                if (dp_ready) bypassed = 1'b1;
            end
`endif
            if (dp_ready && sz > 0) begin
                exp = sb_q.pop_front();
                check("pop_valid", 32'(ib_dp_packet.valid), 32'd1);
                check("pop_pc", ib_dp_packet.PC, exp.PC);
                check("pop_inst", ib_dp_packet.inst, exp.inst);
                check("pop_npc", ib_dp_packet.NPC, exp.NPC);
                check("pop_pred", 32'(ib_dp_packet.pred_bp_taken), 32'(exp.pred_bp_taken));
            end
            if (if_ib_packet.valid) begin
                if (sz == DEPTH) m_ovf = 1'b1;
                else if (!bypassed) sb_q.push_back(if_ib_packet);
            end
        end
        @(posedge clock);
        #1;
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic check_state(input string name);
        int sz;
        sz = sb_q.size();
        check({name, "_count"}, 32'(ib_count), 32'(sz));
        check({name, "_full"}, 32'(ib_full), 32'(sz == DEPTH));
        check({name, "_empty"}, 32'(ib_empty), 32'(sz == 0));
        check({name, "_valid"}, 32'(ib_dp_packet.valid), 32'(sz != 0));
        check({name, "_ovf"}, 32'(ib_overflow_err), 32'(m_ovf));
        if (sz > 0) check({name, "_head_pc"}, ib_dp_packet.PC, sb_q[0].PC);
        else        check({name, "_idle_inst"}, ib_dp_packet.inst, NOP_INST);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sent;
        int          got;
        logic [31:0] last_pc;
        logic        v;
        logic        r;

        tbl[0]  = '{1'b1, 32'h00, 1'b0, 1'b0, 1, 1'b0, 1'b0, 32'h00};
        tbl[1]  = '{1'b1, 32'h04, 1'b0, 1'b0, 2, 1'b0, 1'b0, 32'h00};
        tbl[2]  = '{1'b1, 32'h08, 1'b0, 1'b0, 3, 1'b0, 1'b0, 32'h00};
        tbl[3]  = '{1'b1, 32'h0C, 1'b0, 1'b0, 4, 1'b0, 1'b0, 32'h00};
        tbl[4]  = '{1'b1, 32'h10, 1'b0, 1'b0, 5, 1'b0, 1'b0, 32'h00};
        tbl[5]  = '{1'b0, 32'h14, 1'b0, 1'b0, 5, 1'b0, 1'b0, 32'h00};
        tbl[6]  = '{1'b1, 32'h14, 1'b0, 1'b0, 6, 1'b0, 1'b0, 32'h00};
        tbl[7]  = '{1'b1, 32'h18, 1'b0, 1'b0, 7, 1'b0, 1'b0, 32'h00};
        tbl[8]  = '{1'b1, 32'h1C, 1'b0, 1'b0, 8, 1'b1, 1'b0, 32'h00};
        tbl[9]  = '{1'b1, 32'h20, 1'b0, 1'b0, 8, 1'b1, 1'b1, 32'h00};
        tbl[10] = '{1'b1, 32'h24, 1'b1, 1'b0, 7, 1'b0, 1'b1, 32'h04};
        tbl[11] = '{1'b1, 32'h24, 1'b0, 1'b0, 8, 1'b1, 1'b1, 32'h04};

        m_ovf   = 1'b0;
        reset_n = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        check("rst_empty", 32'(ib_empty), 32'd1);
        check("rst_full", 32'(ib_full), 32'd0);
        check("rst_count", 32'(ib_count), 32'd0);
        check("rst_inst", ib_dp_packet.inst, NOP_INST);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Fill, overflow and full-with-pop behaviour from the vector table.
        for (int i = 0; i < 12; i++) begin
            set_in(tbl[i].v, tbl[i].pc, tbl[i].rdy, tbl[i].fl);
            commit();
            check($sformatf("vec%0d_count", i), 32'(ib_count), 32'(tbl[i].e_cnt));
            check($sformatf("vec%0d_full", i), 32'(ib_full), 32'(tbl[i].e_full));
            check($sformatf("vec%0d_empty", i), 32'(ib_empty), 32'(tbl[i].e_cnt == 0));
            check($sformatf("vec%0d_ovf", i), 32'(ib_overflow_err), 32'(tbl[i].e_ovf));
            check($sformatf("vec%0d_head", i), ib_dp_packet.PC, tbl[i].e_head);
        end
        check_state("after_table");

        repeat (4) begin
            set_in(1'b0, 32'h0, 1'b1, 1'b0);
            commit();
        end
        check_state("drain4");
        check("drain4_head", ib_dp_packet.PC, 32'h14);

        // Asynchronous reset mid-cycle with 4 entries and the overflow flag set.
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_empty", 32'(ib_empty), 32'd1);
        check("arst_full", 32'(ib_full), 32'd0);
        check("arst_count", 32'(ib_count), 32'd0);
        check("arst_valid", 32'(ib_dp_packet.valid), 32'd0);
        check("arst_inst", ib_dp_packet.inst, NOP_INST);
        check("arst_ovf", 32'(ib_overflow_err), 32'd0);
        sb_q.delete();
        m_ovf = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Flush with a push offered and dispatch ready: everything squashed.
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0);
            commit();
        end
        check_state("pre_flush");
        set_in(1'b1, 32'h300, 1'b1, 1'b1);
        commit();
        check("flush_empty", 32'(ib_empty), 32'd1);
        check("flush_count", 32'(ib_count), 32'd0);
        check("flush_valid", 32'(ib_dp_packet.valid), 32'd0);
        check("flush_inst", ib_dp_packet.inst, NOP_INST);
        set_in(1'b1, 32'h304, 1'b0, 1'b0);
        commit();
        check("post_flush_count", 32'(ib_count), 32'd1);
        check("post_flush_head", ib_dp_packet.PC, 32'h304);
        set_in(1'b0, 32'h0, 1'b1, 1'b0);
        commit();
        check_state("post_flush_drain");

        // Empty buffer, push PC=0x40 with dispatch ready.
        set_in(1'b1, 32'h40, 1'b1, 1'b0);
`ifdef IB_BYPASS_EN
        check("byp_same_valid", 32'(ib_dp_packet.valid), 32'd1);
        check("byp_same_pc", ib_dp_packet.PC, 32'h40);
`else
        check("lat_same_valid", 32'(ib_dp_packet.valid), 32'd0);
        check("lat_same_inst", ib_dp_packet.inst, NOP_INST);
`endif
        commit();
`ifdef IB_BYPASS_EN
        check("byp_next_count", 32'(ib_count), 32'd0);
        check("byp_next_empty", 32'(ib_empty), 32'd1);
`else
        check("lat_next_valid", 32'(ib_dp_packet.valid), 32'd1);
        check("lat_next_pc", ib_dp_packet.PC, 32'h40);
`endif
        set_in(1'b0, 32'h0, 1'b1, 1'b0);
        commit();
        check_state("bypass_drain");

        // Continuous 20-packet stream through wrapping pointers, back-pressured by ib_full.
        sent    = 0;
        got     = 0;
        last_pc = 32'h1000 - 32'd4;
        for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
            v = (sent < 20) && !ib_full;
            r = (cyc >= 10) && ($urandom_range(0, 3) != 0);
            set_in(v, 32'h1000 + 32'(4 * sent), r, 1'b0);
            if (r && ib_dp_packet.valid) begin
                check($sformatf("stream_pc%0d", got), ib_dp_packet.PC, last_pc + 32'd4);
                last_pc = ib_dp_packet.PC;
                got++;
            end
            if (v) sent++;
            commit();
        end
        check("stream_received", 32'(got), 32'd20);
        check_state("stream_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
